// File: rtl/axil_store_unpacker_pkg.sv
// Shared AXI-Lite types and the packed-store command layout used by both
// the store packer and the unpacker.
package axil_store_unpacker_pkg;

    typedef enum logic [2:0] {
        e_axi_prot_default = 3'b000,
        e_axi_prot_priv    = 3'b001,
        e_axi_prot_nonsec  = 3'b010,
        e_axi_prot_instr   = 3'b100
    } axi_prot_type_e;

    typedef enum logic [1:0] {
        e_axi_resp_okay   = 2'b00,
        e_axi_resp_exokay = 2'b01,
        e_axi_resp_slverr = 2'b10,
        e_axi_resp_decerr = 2'b11
    } axi_resp_type_e;

    typedef struct packed {
        logic        w_not_r;
        logic [22:0] addr;
        logic [7:0]  data;
    } axil_store_cmd_s;

    typedef enum logic [2:0] {
        e_ready,
        e_write,
        e_write_resp,
        e_read_addr,
        e_read_resp,
        e_read_ret
    } axil_store_unpacker_state_e;

    localparam logic [31:0] axil_err_ret_data_gp  = 32'hDEAD_BEEF;
    localparam logic [15:0] axil_err_count_max_gp = 16'hFFFF;

    function automatic logic axil_resp_is_err(input logic [1:0] resp);
        return resp != e_axi_resp_okay;
    endfunction

endpackage

// File: rtl/axil_store_unpacker_lane.sv
// Byte-lane steering: replicates the write byte, builds the strobe and
// right-aligns read data for the addressed lane.
module axil_store_unpacker_lane
    import axil_store_unpacker_pkg::*;
#(
    parameter int data_width_p = 32
) (
    input  logic [$clog2(data_width_p/8)-1:0] lane_i,
    input  logic [7:0]                        byte_i,
    input  logic [data_width_p-1:0]           rdata_i,
    output logic [data_width_p-1:0]           wdata_o,
    output logic [data_width_p/8-1:0]         wstrb_o,
    output logic [31:0]                       rdata_o
);

    localparam int strb_w_lp = data_width_p / 8;

    assign wdata_o = {strb_w_lp{byte_i}};
    assign wstrb_o = strb_w_lp'(1) << lane_i;
    assign rdata_o = 32'(rdata_i >> {lane_i, 3'b000});

endmodule

// File: rtl/axil_store_unpacker.sv
// Replays packed store/load command words as single AXI4-Lite transactions.
// Optional error counting and poisoned read data: AXIL_STORE_UNPACKER_ERR_EN.
module axil_store_unpacker
    import axil_store_unpacker_pkg::*;
#(
    parameter int                          axi_addr_width_p = 32,
    parameter int                          axi_data_width_p = 32,
    parameter logic [axi_addr_width_p-1:0] base_addr_p      = '0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    input  logic [31:0]                   data_i,
    input  logic                          v_i,
    output logic                          ready_o,

    output logic [31:0]                   data_o,
    output logic                          v_o,
    input  logic                          ready_i,

    output logic [axi_addr_width_p-1:0]   m_axi_awaddr_o,
    output logic [2:0]                    m_axi_awprot_o,
    output logic                          m_axi_awvalid_o,
    input  logic                          m_axi_awready_i,

    output logic [axi_data_width_p-1:0]   m_axi_wdata_o,
    output logic [axi_data_width_p/8-1:0] m_axi_wstrb_o,
    output logic                          m_axi_wvalid_o,
    input  logic                          m_axi_wready_i,

    input  logic [1:0]                    m_axi_bresp_i,
    input  logic                          m_axi_bvalid_i,
    output logic                          m_axi_bready_o,

    output logic [axi_addr_width_p-1:0]   m_axi_araddr_o,
    output logic [2:0]                    m_axi_arprot_o,
    output logic                          m_axi_arvalid_o,
    input  logic                          m_axi_arready_i,

    input  logic [axi_data_width_p-1:0]   m_axi_rdata_i,
    input  logic [1:0]                    m_axi_rresp_i,
    input  logic                          m_axi_rvalid_i,
    output logic                          m_axi_rready_o
`ifdef AXIL_STORE_UNPACKER_ERR_EN
    ,
    output logic [15:0]                   err_count_o
`endif
);

    localparam int aw_lp   = axi_addr_width_p;
    localparam int dw_lp   = axi_data_width_p;
    localparam int lane_lp = $clog2(dw_lp / 8);

    // Low 23 bits of the base come from the command, never the parameter.
    localparam logic [aw_lp-1:0] base_hi_lp =
        base_addr_p & ~aw_lp'(23'h7F_FFFF);

    axil_store_unpacker_state_e state_q, state_d;
    axil_store_cmd_s            cmd_q, cmd_d;
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;
    logic [31:0]                ret_q, ret_d;

    logic [aw_lp-1:0]   addr;
    logic [dw_lp-1:0]   lane_wdata;
    logic [dw_lp/8-1:0] lane_wstrb;
    logic [31:0]        lane_rdata;
    logic               rd_err;

    logic awvalid, wvalid, arvalid;

    assign addr = base_hi_lp | aw_lp'(cmd_q.addr);

    axil_store_unpacker_lane #(
        .data_width_p(dw_lp)
    ) lane_u (
        .lane_i (cmd_q.addr[lane_lp-1:0]),
        .byte_i (cmd_q.data),
        .rdata_i(m_axi_rdata_i),
        .wdata_o(lane_wdata),
        .wstrb_o(lane_wstrb),
        .rdata_o(lane_rdata)
    );

`ifdef AXIL_STORE_UNPACKER_ERR_EN
    logic [15:0] err_count_q, err_count_d;
    logic        err_hs;
    logic        unused_sig;

    assign rd_err = axil_resp_is_err(m_axi_rresp_i);

    assign err_hs =
        (m_axi_bready_o & m_axi_bvalid_i & axil_resp_is_err(m_axi_bresp_i))
      | (m_axi_rready_o & m_axi_rvalid_i & rd_err);

    always_comb begin
        err_count_d = err_count_q;
        if (err_hs && (err_count_q != axil_err_count_max_gp)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count_o = err_count_q;
    assign unused_sig  = cmd_q.w_not_r;
`else
    logic unused_sig;

    // Responses are deliberately ignored in this build.
    assign rd_err     = 1'b0;
    assign unused_sig = ^{cmd_q.w_not_r, m_axi_bresp_i, m_axi_rresp_i};
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ret_d     = ret_q;

        ready_o        = 1'b0;
        v_o            = 1'b0;
        awvalid        = 1'b0;
        wvalid         = 1'b0;
        arvalid        = 1'b0;
        m_axi_bready_o = 1'b0;
        m_axi_rready_o = 1'b0;

        unique case (state_q)
            e_ready: begin
                ready_o = 1'b1;
                if (v_i) begin
                    cmd_d     = axil_store_cmd_s'(data_i);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = data_i[31] ? e_write : e_read_addr;
                end
            end
            e_write: begin
                awvalid   = ~aw_done_q;
                wvalid    = ~w_done_q;
                aw_done_d = aw_done_q | m_axi_awready_i;
                w_done_d  = w_done_q | m_axi_wready_i;
                if (aw_done_d && w_done_d) begin
                    state_d = e_write_resp;
                end
            end
            e_write_resp: begin
                m_axi_bready_o = 1'b1;
                if (m_axi_bvalid_i) begin
                    state_d = e_ready;
                end
            end
            e_read_addr: begin
                arvalid = 1'b1;
                if (m_axi_arready_i) begin
                    state_d = e_read_resp;
                end
            end
            e_read_resp: begin
                m_axi_rready_o = 1'b1;
                if (m_axi_rvalid_i) begin
                    ret_d   = rd_err ? axil_err_ret_data_gp : lane_rdata;
                    state_d = e_read_ret;
                end
            end
            e_read_ret: begin
                v_o = 1'b1;
                if (ready_i) begin
                    state_d = e_ready;
                end
            end
            default: begin
                state_d = e_ready;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_ready;
            cmd_q     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ret_q     <= ret_d;
        end
    end

    // Buses read as zero whenever their valid is low.
    assign m_axi_awvalid_o = awvalid;
    assign m_axi_awaddr_o  = awvalid ? addr : '0;
    assign m_axi_awprot_o  = e_axi_prot_default;

    assign m_axi_wvalid_o  = wvalid;
    assign m_axi_wdata_o   = wvalid ? lane_wdata : '0;
    assign m_axi_wstrb_o   = wvalid ? lane_wstrb : '0;

    assign m_axi_arvalid_o = arvalid;
    assign m_axi_araddr_o  = arvalid ? addr : '0;
    assign m_axi_arprot_o  = e_axi_prot_default;

    assign data_o = v_o ? ret_q : 32'd0;

endmodule
